ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 156 +++++++++++++++
 tb/tb_ifetch_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue sitting between an in-order
// instruction memory port and the decode stage.
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   Redirect         flush queue and restart fetch at RedirectPC
//   RedirectPC       restart address, bits [1:0] ignored
//   StallF           consumer is not taking the head entry this cycle
//   ValidF           head entry valid
//   InstrF/PCF       head instruction and its address
//   PCPlus4F         PCF + 4 (mod 2^32)
//   ImemReq/ImemAddr fetch request, held stable until ImemGnt
//   ImemGnt          request accepted this cycle
//   ImemRvalid/Rdata in-order response from the memory
//
// Build option
//   IFETCH_QUEUE_BYPASS_EN  a live response into an empty queue drives the
//                           head outputs in the same cycle, and is consumed
//                           without being stored when StallF=0.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        StallF,
  output logic        ValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          started_q,  started_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] out_q,      out_d;
  logic [CW-1:0] drop_q,     drop_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];

  logic [SW-1:0] total;
  logic          grant, resp_drop, resp_take, q_empty;
  logic          byp_valid, pop, pop_q, byp_consumed, push;
  logic [31:0]   redirect_pc;
  logic          unused_rpc_bits;

  assign redirect_pc     = {RedirectPC[31:2], 2'b00};
  assign unused_rpc_bits = ^RedirectPC[1:0];

  always_comb begin
    // Drops still count against capacity: their responses are yet to arrive.
    total     = SW'(count_q) + SW'(out_q) + SW'(drop_q);
    ImemReq   = started_q && (total < SW'(DEPTH));
    ImemAddr  = fetch_pc_q;
    grant     = ImemReq && ImemGnt;
    // Responses retire drops first; they belong to the oldest requests.
    resp_drop = ImemRvalid && (drop_q != '0);
    resp_take = ImemRvalid && (drop_q == '0) && (out_q != '0);
    q_empty   = (count_q == '0);

`ifdef IFETCH_QUEUE_BYPASS_EN
    byp_valid = resp_take && q_empty && !Redirect;
`else
    byp_valid = 1'b0;
`endif

    ValidF = !q_empty || byp_valid;
    if (!q_empty) begin
      InstrF = instr_mem_q[rd_ptr_q];
      PCF    = pc_mem_q[rd_ptr_q];
    end else begin
      InstrF = byp_valid ? ImemRdata : NOP;
      PCF    = resp_pc_q;
    end
    PCPlus4F = PCF + 32'd4;

    pop          = ValidF && !StallF && !Redirect;
    pop_q        = pop && !q_empty;
    byp_consumed = pop && q_empty;
    push         = resp_take && !Redirect && !byp_consumed;

    started_d   = 1'b1;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    rd_ptr_d    = rd_ptr_q + AW'(pop_q);
    wr_ptr_d    = wr_ptr_q + AW'(push);
    count_d     = count_q + CW'(push) - CW'(pop_q);
    fetch_pc_d  = grant ? (fetch_pc_q + 32'd4) : fetch_pc_q;
    resp_pc_d   = resp_take ? (resp_pc_q + 32'd4) : resp_pc_q;
    out_d       = out_q + CW'(grant) - CW'(resp_take);
    drop_d      = drop_q - CW'(resp_drop);

    if (push) begin
      instr_mem_d[wr_ptr_q] = ImemRdata;
      pc_mem_d[wr_ptr_q]    = resp_pc_q;
    end

    // Everything in flight, including this cycle's grant and minus this
    // cycle's response, becomes a drop.
    if (Redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      out_d      = '0;
      drop_d     = drop_q + out_q + CW'(grant) - CW'(resp_drop) - CW'(resp_take);
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      started_q   <= started_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect, stall, gnt, rvalid;
  logic [31:0] rpc, rdata;
  logic        valid, req;
  logic [31:0] instr, pcf, pcp4, addr;

  logic        v1, req1, rvalid1;
  logic [31:0] i1, p1, pp1, addr1, rdata1;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(rst_n), .Redirect(redirect), .RedirectPC(rpc),
    .StallF(stall), .ValidF(valid), .InstrF(instr), .PCF(pcf),
    .PCPlus4F(pcp4), .ImemReq(req), .ImemAddr(addr), .ImemGnt(gnt),
    .ImemRvalid(rvalid), .ImemRdata(rdata)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(rst_n), .Redirect(1'b0), .RedirectPC(32'h0),
    .StallF(1'b0), .ValidF(v1), .InstrF(i1), .PCF(p1),
    .PCPlus4F(pp1), .ImemReq(req1), .ImemAddr(addr1), .ImemGnt(1'b1),
    .ImemRvalid(rvalid1), .ImemRdata(rdata1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Behavioural model: address queue of requests in flight, drop count,
  // and a list of delivered {pc, instr} entries.
  logic [31:0] m_out[$];
  logic [31:0] m_pc[$];
  logic [31:0] m_ins[$];
  int          m_drops = 0;
  logic [31:0] m_fpc = 32'h0;
  bit          m_started = 0;

  // Memory model and logs
  logic [31:0] memq[$];
  logic [31:0] grant_log[$];
  logic [31:0] log1[$];
  bit          rsp_from_q = 0;
  bit          resp_en = 1;
  bit          spurious = 0;

  task automatic step();
    bit          hs, hs1, m_req, m_valid, byp;
    logic [31:0] hs_a, hs1_a, e_pc, e_ins, a;
    m_req = 0; byp = 0;
    @(negedge clk);
    hs = req && gnt; hs_a = addr; hs1 = req1; hs1_a = addr1;
    if (!rst_n) begin
      chk("rst ValidF", valid, 0);
      chk("rst ImemReq", req, 0);
      chk("rst ImemAddr", addr, 32'h0);
      chk("rst InstrF", instr, 32'h0000_0013);
      chk("rst PCF", pcf, 32'h0);
      chk("rst PCPlus4F", pcp4, 32'h4);
      chk("rst1 ImemAddr", addr1, 32'hFFFF_FFF8);
      chk("rst1 PCPlus4F", pp1, 32'hFFFF_FFFC);
    end else begin
      m_req = m_started && ((m_drops + m_out.size() + m_pc.size()) < DEPTH);
`ifdef IFETCH_QUEUE_BYPASS_EN
      byp = (m_pc.size() == 0) && rvalid && (m_drops == 0) && (m_out.size() > 0) && !redirect;
`endif
      m_valid = (m_pc.size() > 0) || byp;
      chk("ValidF", valid, m_valid);
      chk("ImemReq", req, m_req);
      if (m_req) chk("ImemAddr", addr, m_fpc);
      if (m_valid) begin
        e_pc  = (m_pc.size() > 0) ? m_pc[0] : m_out[0];
        e_ins = (m_pc.size() > 0) ? m_ins[0] : rdata;
        chk("PCF", pcf, e_pc);
        chk("InstrF", instr, e_ins);
        chk("PCPlus4F", pcp4, e_pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_out.delete(); m_pc.delete(); m_ins.delete();
      m_drops = 0; m_fpc = 32'h0; m_started = 0;
    end else begin
      if (m_pc.size() > 0 && !stall && !redirect) begin
        void'(m_pc.pop_front());
        void'(m_ins.pop_front());
      end
      if (rvalid) begin
        if (m_drops > 0) m_drops--;
        else if (m_out.size() > 0) begin
          a = m_out.pop_front();
          if (!redirect && !(byp && !stall)) begin
            m_pc.push_back(a);
            m_ins.push_back(rdata);
          end
        end
      end
      if (m_req && gnt) begin
        m_out.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
      if (redirect) begin
        m_drops = m_drops + m_out.size();
        m_out.delete(); m_pc.delete(); m_ins.delete();
        m_fpc = {rpc[31:2], 2'b00};
      end
      m_started = 1;
    end
    if (!rst_n) begin
      memq.delete();
      rvalid = 0; rvalid1 = 0; rsp_from_q = 0;
    end else begin
      if (rsp_from_q) void'(memq.pop_front());
      if (hs) begin memq.push_back(hs_a); grant_log.push_back(hs_a); end
      if (hs1) log1.push_back(hs1_a);
      rvalid1 = hs1; rdata1 = hs1_a;
      if (resp_en && memq.size() > 0) begin
        rvalid = 1; rdata = mem_data(memq[0]); rsp_from_q = 1;
      end else if (spurious) begin
        rvalid = 1; rdata = 32'hDEAD_BEEF; rsp_from_q = 0;
      end else begin
        rvalid = 0; rsp_from_q = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    grant_log.delete();
    log1.delete();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (valid) seen = 1;
    end
    chk({name, " seen"}, seen, 1);
    if (seen) begin
      chk({name, " PCF"}, pcf, exp_pc);
      chk({name, " InstrF"}, instr, exp_ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen1;
    rst_n = 0; redirect = 0; rpc = '0; stall = 0; gnt = 0;
    rvalid = 0; rdata = '0; rvalid1 = 0; rdata1 = '0;

    // Reset values and zero-wait streaming
    repeat (3) step();
    chk("reset PCPlus4F", pcp4, 32'h4);
    rst_n = 1; gnt = 1;
    grant_log.delete();
    step();
    chk("first req", req, 1);
    chk("first addr", addr, 32'h0);
    step();
`ifndef IFETCH_QUEUE_BYPASS_EN
    chk("no valid 1 cyc after grant", valid, 0);
`endif
    step();
    chk("valid 2 cyc after grant", valid, 1);
    chk("first PCF", pcf, 32'h0);
    chk("first InstrF", instr, 32'h0000_FFFF);
    step(); step();
    chk("grant count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("stream addr", grant_log[i], 32'(i * 4));

    // Stall with a full queue, then drain in order
    stall = 1;
    do_reset();
    repeat (12) step();
    chk("stall grants", grant_log.size(), 4);
    chk("stall req", req, 0);
    chk("stall valid", valid, 1);
    chk("stall head PCF", pcf, 32'h0);
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      chk("drain PCF", pcf, 32'(i * 4));
      step();
    end
    // Redirect wins over StallF with a full queue
    stall = 1;
    repeat (8) step();
    redirect = 1; rpc = 32'h0000_0040;
    step();
    redirect = 0;
    chk("redirect+stall valid", valid, 0);
    chk("redirect+stall addr", addr, 32'h40);
    stall = 0;
    wait_valid("redir stall", 32'h40, mem_data(32'h40));

    // Redirect with 3 outstanding, misaligned target
    resp_en = 0; gnt = 1;
    do_reset();
    repeat (4) step();
    gnt = 0; redirect = 1; rpc = 32'h0000_0102;
    step();
    redirect = 0;
    chk("redir addr", addr, 32'h100);
    chk("redir req", req, 1);
    gnt = 1; resp_en = 1;
    wait_valid("redir3", 32'h100, 32'h0100_FEFF);

    // Redirect in the same cycle as a response
    do_reset();
    step(); step();
    chk("resp this cycle", rvalid, 1);
    gnt = 0; redirect = 1; rpc = 32'h0000_0200;
    step();
    redirect = 0;
    chk("redir+rvalid valid", valid, 0);
    gnt = 1;
    wait_valid("redir rvalid", 32'h200, 32'h0200_FDFF);

    // Unsolicited responses are ignored
    gnt = 0;
    do_reset();
    spurious = 1;
    repeat (4) step();
    chk("spurious valid", valid, 0);
    spurious = 0; gnt = 1;
    wait_valid("after spurious", 32'h0, 32'h0000_FFFF);

    // Address wrap on the second instance
    do_reset();
    seen1 = 0;
    repeat (8) begin
      step();
      if (v1 && p1 == 32'hFFFF_FFFC) begin
        seen1 = 1;
        chk("wrap PCPlus4F", pp1, 32'h0);
      end
    end
    chk("wrap head seen", seen1, 1);
    chk("wrap grants", log1.size() >= 3, 1);
    if (log1.size() >= 3) begin
      chk("wrap addr0", log1[0], 32'hFFFF_FFF8);
      chk("wrap addr1", log1[1], 32'hFFFF_FFFC);
      chk("wrap addr2", log1[2], 32'h0000_0000);
    end

`ifdef IFETCH_QUEUE_BYPASS_EN
    // Same-cycle bypass into an empty queue
    gnt = 1; resp_en = 0;
    do_reset();
    step();
    gnt = 0;
    step();
    resp_en = 1;
    step();
    rvalid = 1; rdata = 32'h0050_0093;
    #1;
    chk("bypass ValidF", valid, 1);
    chk("bypass InstrF", instr, 32'h0050_0093);
    step();
    chk("bypass consumed", valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
